// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single shared memory bus.
// Data has priority; a starve counter guarantees fetch a grant after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic        mem_rw,
  output logic [31:0] mem_wdata,
  output logic        mem_wdata_oe,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  localparam int unsigned    CW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [31:0]   lat_addr_q, lat_addr_d;
  logic [31:0]   lat_wdata_q, lat_wdata_d;
  logic [1:0]    lat_size_q, lat_size_d;
  logic          lat_rw_q, lat_rw_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]    mem_size_q, mem_size_d;
  logic          mem_rw_q, mem_rw_d;
  logic          mem_oe_q, mem_oe_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          busy_q, busy_d;
  logic          any_req, data_wins, on_bus;

  function automatic logic [31:0] zext(input logic [1:0] size, input logic [31:0] value);
    case (size)
      2'b01:   return {24'b0, value[7:0]};
      2'b10:   return {16'b0, value[15:0]};
      default: return value;
    endcase
  endfunction

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves one unassigned (no latch).
    state_d     = state_q;
    grant_d     = grant_q;
    starve_d    = starve_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_size_d  = lat_size_q;
    lat_rw_d    = lat_rw_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;

    any_req   = if_req | d_req;
    data_wins = d_req & ~(if_req & (starve_q == LIMIT));

    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = data_wins;
          if (data_wins) begin
            lat_addr_d  = d_addr;
            lat_size_d  = d_size;
            lat_rw_d    = d_rw;
            lat_wdata_d = d_wdata;
            // A zero-size access never touches the bus and completes with zero data.
            if (d_size == 2'b00) begin
              state_d   = RESP;
              d_ack_d   = 1'b1;
              d_rdata_d = '0;
            end else begin
              state_d = ADDR;
            end
          end else begin
            lat_addr_d  = if_addr;
            lat_size_d  = 2'b11;
            lat_rw_d    = 1'b0;
            lat_wdata_d = '0;
            state_d     = ADDR;
          end
        end
      end
      ADDR: begin
        if (lat_rw_q) begin
          state_d  = RESP;
          d_ack_d  = grant_q;
          if_ack_d = ~grant_q;
        end else begin
          state_d = DATA;
        end
      end
      DATA: begin
        state_d = RESP;
        if (grant_q) begin
          d_ack_d   = 1'b1;
          d_rdata_d = zext(lat_size_q, mem_rdata);
        end else begin
          if_ack_d   = 1'b1;
          if_rdata_d = zext(lat_size_q, mem_rdata);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!if_req) begin
      starve_d = '0;
    end else if (state_q == IDLE && any_req) begin
      if (!data_wins)              starve_d = '0;
      else if (starve_q != LIMIT)  starve_d = starve_q + CW'(1);
    end

    // Bus outputs are registered from the next state so they line up with ADDR/DATA exactly.
    on_bus      = (state_d == ADDR) || (state_d == DATA);
    mem_addr_d  = on_bus ? lat_addr_d  : '0;
    mem_size_d  = on_bus ? lat_size_d  : 2'b00;
    mem_rw_d    = on_bus & lat_rw_d;
    mem_wdata_d = on_bus ? lat_wdata_d : '0;
    mem_oe_d    = on_bus & lat_rw_d;
    busy_d      = (state_d != IDLE);
  end

  // NOTE: reset is asynchronous here, so an abort clears every flop immediately, mid-cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      starve_q    <= '0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_size_q  <= 2'b00;
      lat_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= 2'b00;
      mem_rw_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      state_q     <= state_d;
      grant_q     <= grant_d;
      starve_q    <= starve_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_size_q  <= lat_size_d;
      lat_rw_q    <= lat_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      mem_rw_q    <= mem_rw_d;
      mem_oe_q    <= mem_oe_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_ack       = if_ack_q;
  assign if_rdata     = if_rdata_q;
  assign d_ack        = d_ack_q;
  assign d_rdata      = d_rdata_q;
  assign mem_addr     = mem_addr_q;
  assign mem_size     = mem_size_q;
  assign mem_rw       = mem_rw_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wdata_oe = mem_oe_q;
  assign busy         = busy_q;
  assign grant        = grant_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data-port grants while fetch is pending.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port if_req, input, 1: fetch-port request; 32-bit word read.
REQ-005 SHALL have port if_addr, input, 32: fetch address.
REQ-006 SHALL have port if_ack, output, 1: one-cycle completion pulse for the fetch port.
REQ-007 SHALL have port if_rdata, output, 32: fetch result, valid while if_ack=1.
REQ-008 SHALL have port d_req, input, 1: data-port request.
REQ-009 SHALL have ports d_rw (input, 1: 1=write), d_size (input, 2: 00 none, 01 byte, 10 half, 11 word), d_addr (input, 32) and d_wdata (input, 32).
REQ-010 SHALL have ports d_ack (output, 1: completion pulse) and d_rdata (output, 32: valid while d_ack=1).
REQ-011 SHALL have ports mem_addr (output, 32), mem_size (output, 2), mem_rw (output, 1) and mem_wdata (output, 32) to the shared memory bus.
REQ-012 SHALL have ports mem_wdata_oe (output, 1: enable for the external tristate driver of the data bus) and mem_rdata (input, 32: resolved data bus).
REQ-013 SHALL have ports busy (output, 1: transaction in progress) and grant (output, 1: 0=fetch, 1=data; valid while busy=1).

Function
REQ-014 SHALL implement the states IDLE, ADDR, DATA and RESP.
REQ-015 IDLE SHALL, when any request is present, latch the winner's addr/size/rw/wdata, set grant, and go to ADDR; otherwise it SHALL stay in IDLE.
REQ-016 Arbitration SHALL give data priority over fetch, except when the starve counter equals STARVE_LIMIT and if_req=1, in which case fetch SHALL win.
REQ-017 The starve counter SHALL increment on each data grant while if_req=1, clear on each fetch grant or whenever if_req=0, and saturate at STARVE_LIMIT.
REQ-018 ADDR SHALL drive the latched mem_addr/mem_size/mem_rw, with mem_wdata_oe=1 for writes only; a write SHALL go to RESP and a read SHALL go to DATA.
REQ-019 DATA SHALL hold the same bus values and capture mem_rdata at the clock edge ending the cycle, then go to RESP.
REQ-020 RESP SHALL pulse the granted port's ack for exactly 1 cycle and return to IDLE; a new arbitration SHALL occur only in the following IDLE cycle.
REQ-021 Latency from request sampled in IDLE (cycle 0) SHALL be: read ack in cycle 3, write ack in cycle 2.
REQ-022 Read data SHALL be zero-extended by size: 01 returns {24'b0, mem_rdata[7:0]}, 10 returns {16'b0, mem_rdata[15:0]}, 11 returns the full 32 bits.
REQ-023 A fetch request SHALL always use mem_size=11 and mem_rw=0.
REQ-024 A data request with d_size=00 SHALL skip the bus (mem_size stays 00 throughout), go IDLE->RESP, and ack with d_rdata=0 in cycle 1.
REQ-025 The bus SHALL be idle when not in ADDR or DATA: mem_size=00, mem_rw=0, mem_wdata_oe=0, mem_addr=0, mem_wdata=0.
REQ-026 Once granted, a transaction SHALL complete and ack even if its req drops; requester inputs SHALL be ignored after latching.
REQ-027 The ungranted port's ack SHALL be held at 0, and its rdata output SHALL hold its last value.
REQ-028 Misaligned addresses SHALL be passed through unchanged and SHALL not be checked.
REQ-029 busy SHALL be 1 in ADDR, DATA and RESP, and 0 in IDLE.

Reset
REQ-030 While rst=1, the block SHALL asynchronously enter IDLE with all outputs 0, grant=0, starve counter=0, and latched registers=0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no ack and no further bus drive; a write already sampled by memory SHALL not be undone.

Verification
REQ-032 Fetch only: if_req=1, if_addr=0x4, mem_rdata=0x0000A103 in DATA -> if_ack=1 in cycle 3, if_rdata=0x0000A103, with mem_size=11 and mem_rw=0 in cycles 1-2.
REQ-033 Word write: d_req=1, d_rw=1, d_size=11, d_addr=0x10, d_wdata=0xDEADBEEF -> in cycle 1 mem_wdata_oe=1, mem_wdata=0xDEADBEEF and mem_rw=1; d_ack in cycle 2.
REQ-034 Byte read: d_size=01, mem_rdata=0x12345678 -> d_rdata=0x00000078; halfword read (d_size=10) -> d_rdata=0x00005678.
REQ-035 Contention with STARVE_LIMIT=4: if_req and d_req held high continuously -> grant sequence D,D,D,D,F,D,D,D,D,F.
REQ-036 d_size=00 request -> d_ack in cycle 1 with d_rdata=0, and mem_size=00 throughout.
REQ-037 rst pulsed during DATA of a read -> immediate IDLE, no if_ack/d_ack, busy=0, and a subsequent request completes with normal latency.
